// File: rtl/acc_driver_pkg.sv
// Shared types and constants for the accelerator driver: FSM encoding,
// vector/operand widths and operand field offsets inside a packed vector.
package acc_pkg;
    localparam int VEC_W  = 32;
    localparam int OP_W   = 8;
    localparam int CNT_W  = 16;
    localparam int X1_OFS = 0;
    localparam int X2_OFS = 8;
    localparam int X3_OFS = 16;
    localparam int X4_OFS = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_e;
endpackage

// File: rtl/acc_driver_if.sv
// Host write/read port plus accelerator handshake, bundled for the driver.
// master = the driver itself, slave = host + accelerator side.
interface acc_driver_if;
    import acc_pkg::*;

    logic [VEC_W-1:0] in_data;
    logic             in_wr;
    logic             in_full;
    logic [OP_W-1:0]  res_data;
    logic             res_rd;
    logic             res_empty;
    logic [OP_W-1:0]  acc_x1, acc_x2, acc_x3, acc_x4;
    logic             acc_valid;
    logic             acc_ready;
    logic [OP_W-1:0]  acc_y;
    logic             acc_valid_out;
    logic             acc_ready_out;
    logic [CNT_W-1:0] done_cnt;
    logic             err;

    modport master (
        input  in_data, in_wr, res_rd, acc_ready, acc_y, acc_valid_out,
        output in_full, res_data, res_empty, acc_x1, acc_x2, acc_x3, acc_x4,
               acc_valid, acc_ready_out, done_cnt, err
    );

    modport slave (
        output in_data, in_wr, res_rd, acc_ready, acc_y, acc_valid_out,
        input  in_full, res_data, res_empty, acc_x1, acc_x2, acc_x3, acc_x4,
               acc_valid, acc_ready_out, done_cnt, err
    );
endinterface

// File: rtl/acc_driver_sync_fifo.sv
// Small synchronous FIFO; head is read straight from the storage flops.
// Writes when full and reads when empty are dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [WIDTH-1:0] din,
    input  logic             wr,
    input  logic             rd,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW-1:0]               wp_q, rp_q;
    logic [CW-1:0]               cnt_q;
    logic                        do_wr, do_rd;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;
    assign dout  = mem_q[rp_q];

    // Storage is reset too so the head reads 0 straight out of reset.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            mem_q <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wp_q] <= din;
                wp_q        <= wp_q + AW'(1);
            end
            if (do_rd) rp_q <= rp_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_wr) - CW'(do_rd);
        end
    end
endmodule

// File: rtl/acc_driver.sv
// Host-side initiator for the non-pipelined accelerator: issues one buffered
// vector at a time, collects its result, aborts on a hung accelerator.
module acc_driver
    import acc_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input logic          clk,
    input logic          arst,
    acc_driver_if.master bus
);
    localparam int             TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [VEC_W-1:0] acc_x_q, acc_x_d;
    logic             acc_valid_q;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [CNT_W-1:0] done_q, done_d;
    logic             err_q, err_d;

    logic [VEC_W-1:0] in_dout;
    logic             in_empty, in_rd;
    logic             res_full, res_wr;
    logic             ready_out;

    sync_fifo #(.WIDTH(VEC_W), .DEPTH(DEPTH)) u_in_fifo (
        .clk(clk), .arst(arst), .din(bus.in_data), .wr(bus.in_wr), .rd(in_rd),
        .full(bus.in_full), .empty(in_empty), .dout(in_dout)
    );

    sync_fifo #(.WIDTH(OP_W), .DEPTH(DEPTH)) u_res_fifo (
        .clk(clk), .arst(arst), .din(bus.acc_y), .wr(res_wr), .rd(bus.res_rd),
        .full(res_full), .empty(bus.res_empty), .dout(bus.res_data)
    );

    // Result-side ready must not look at acc_valid_out.
    assign ready_out = (state_q == WAIT) && !res_full;

    always_comb begin
        state_d = state_q;
        acc_x_d = acc_x_q;
        tmo_d   = tmo_q;
        done_d  = done_q;
        err_d   = err_q;
        in_rd   = 1'b0;
        res_wr  = 1'b0;
        case (state_q)
            IDLE: if (!in_empty) begin
                acc_x_d = in_dout;
                state_d = SEND;
            end
            SEND: if (bus.acc_ready) begin
                in_rd   = 1'b1;
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A transfer on the last timeout cycle still wins.
                if (bus.acc_valid_out && ready_out) begin
                    res_wr  = 1'b1;
                    done_d  = done_q + CNT_W'(1);
                    state_d = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q     <= IDLE;
            acc_x_q     <= '0;
            acc_valid_q <= 1'b0;
            tmo_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_x_q     <= acc_x_d;
            acc_valid_q <= (state_d == SEND);
            tmo_q       <= tmo_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.acc_x1        = acc_x_q[X1_OFS +: OP_W];
    assign bus.acc_x2        = acc_x_q[X2_OFS +: OP_W];
    assign bus.acc_x3        = acc_x_q[X3_OFS +: OP_W];
    assign bus.acc_x4        = acc_x_q[X4_OFS +: OP_W];
    assign bus.acc_valid     = acc_valid_q;
    assign bus.acc_ready_out = ready_out;
    assign bus.done_cnt      = done_q;
    assign bus.err           = err_q;
endmodule

// File: tb/tb_acc_driver.sv
// Bench for acc_driver: transaction-level model with queues, per-cycle
// compare, directed scenarios with literal expectations, then random traffic.
module tb_acc_driver;
    import acc_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 64;

    logic clk  = 1'b0;
    logic arst = 1'b0;

    acc_driver_if bus();

    acc_driver #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .arst(arst), .bus(bus)
    );

    always #5 clk = ~clk;

    int  n_chk  = 0;
    int  n_fail = 0;
    bit  chk_en = 1'b0;
    bit  y_auto = 1'b0;

    // Model: what the host has queued, what results wait, and the one
    // transaction (if any) being offered or awaited.
    logic [31:0] in_q[$];
    logic [7:0]  res_q[$];
    bit          m_hold, m_iss, m_err;
    int          m_wait;
    logic [31:0] m_x;
    logic [15:0] m_done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        in_q.delete();
        res_q.delete();
        m_hold = 0; m_iss = 0; m_err = 0; m_wait = 0; m_x = '0; m_done = '0;
    endfunction

    function automatic void model_step();
        bit wr_ok  = bus.in_wr && (in_q.size() < DEPTH);
        bit rd_ok  = bus.res_rd && (res_q.size() > 0);
        bit room   = res_q.size() < DEPTH;
        bit push_r = 0;
        if (!m_hold) begin
            if (in_q.size() > 0) begin
                m_hold = 1; m_iss = 0; m_x = in_q[0];
            end
        end else if (!m_iss) begin
            if (bus.acc_ready) begin
                void'(in_q.pop_front());
                m_iss = 1; m_wait = 0;
            end
        end else if (bus.acc_valid_out && room) begin
            push_r = 1; m_done = m_done + 16'd1; m_hold = 0;
        end else if (m_wait == TMO - 1) begin
            m_err = 1; m_hold = 0;
        end else begin
            m_wait++;
        end
        if (rd_ok)  void'(res_q.pop_front());
        if (push_r) res_q.push_back(bus.acc_y);
        if (wr_ok)  in_q.push_back(bus.in_data);
    endfunction

    always @(posedge clk) if (arst) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            chk("acc_valid", bus.acc_valid, m_hold && !m_iss);
            chk("acc_x1", bus.acc_x1, m_x[7:0]);
            chk("acc_x2", bus.acc_x2, m_x[15:8]);
            chk("acc_x3", bus.acc_x3, m_x[23:16]);
            chk("acc_x4", bus.acc_x4, m_x[31:24]);
            chk("acc_ready_out", bus.acc_ready_out, m_hold && m_iss && (res_q.size() < DEPTH));
            chk("in_full", bus.in_full, in_q.size() == DEPTH);
            chk("res_empty", bus.res_empty, res_q.size() == 0);
            if (res_q.size() != 0) chk("res_data", bus.res_data, res_q[0]);
            chk("done_cnt", bus.done_cnt, m_done);
            chk("err", bus.err, m_err);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (y_auto) bus.acc_y = bus.acc_x1 + bus.acc_x4;
    endtask

    task automatic cycles(input int n);
        repeat (n) cyc();
    endtask

    task automatic push_vec(input logic [31:0] v);
        bus.in_wr = 1'b1; bus.in_data = v;
        cyc();
        bus.in_wr = 1'b0;
    endtask

    task automatic pop_res();
        bus.res_rd = 1'b1;
        cyc();
        bus.res_rd = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int lim);
        int k = 0;
        while (!bus.acc_valid && k < lim) begin
            cyc();
            k++;
        end
        chk(nm, bus.acc_valid, 1);
    endtask

    // x1 + x4 of vec(i) is 2*i (mod 256), giving predictable results.
    function automatic logic [31:0] vec(input int i);
        logic [7:0] b4 = 8'(8'h40 + i);
        logic [7:0] b3 = 8'(8'hA0 + i);
        logic [7:0] b2 = 8'(5 * i);
        logic [7:0] b1 = 8'(8'hC0 + i);
        return {b4, b3, b2, b1};
    endfunction

    initial begin
        logic [15:0] d0;
        bus.in_data = '0; bus.in_wr = 0; bus.res_rd = 0;
        bus.acc_ready = 0; bus.acc_y = '0; bus.acc_valid_out = 0;
        model_reset();
        chk_en = 1'b1;

        #2;
        chk("rst_acc_valid", bus.acc_valid, 0);
        chk("rst_ready_out", bus.acc_ready_out, 0);
        chk("rst_in_full", bus.in_full, 0);
        chk("rst_res_empty", bus.res_empty, 1);
        chk("rst_res_data", bus.res_data, 8'h00);
        chk("rst_done", bus.done_cnt, 16'h0000);
        chk("rst_err", bus.err, 0);
        chk("rst_x1", bus.acc_x1, 8'h00);
        cycles(2);
        arst = 1'b1;
        cyc();

        // Single vector with literal operand and result expectations.
        push_vec(32'h10F07F81);
        wait_valid("t1_valid", 5);
        chk("t1_x1", bus.acc_x1, 8'h81);
        chk("t1_x2", bus.acc_x2, 8'h7F);
        chk("t1_x3", bus.acc_x3, 8'hF0);
        chk("t1_x4", bus.acc_x4, 8'h10);
        cyc();
        chk("t1_valid_hold", bus.acc_valid, 1);
        bus.acc_ready = 1; cyc(); bus.acc_ready = 0;
        chk("t1_valid_fall", bus.acc_valid, 0);
        chk("t1_x1_after", bus.acc_x1, 8'h81);
        cycles(2);
        bus.acc_valid_out = 1; bus.acc_y = 8'h2A; cyc(); bus.acc_valid_out = 0;
        chk("t1_res_empty", bus.res_empty, 0);
        chk("t1_res_data", bus.res_data, 8'h2A);
        chk("t1_done", bus.done_cnt, 16'd1);
        chk("t1_err", bus.err, 0);
        pop_res();
        chk("t1_drained", bus.res_empty, 1);

        // Input backpressure: ten cycles with acc_ready low.
        push_vec(32'h01020304);
        wait_valid("t2_valid", 5);
        for (int i = 0; i < 10; i++) begin
            chk("t2_valid_held", bus.acc_valid, 1);
            chk("t2_x2_stable", bus.acc_x2, 8'h03);
            cyc();
        end
        bus.acc_ready = 1; cyc(); bus.acc_ready = 0;
        bus.acc_valid_out = 1; bus.acc_y = 8'h55; cyc(); bus.acc_valid_out = 0;
        cycles(3);
        chk("t2_single_pop", bus.acc_valid, 0);
        chk("t2_res", bus.res_data, 8'h55);
        pop_res();

        // Input overflow: DEPTH+1 writes, last one lost.
        for (int i = 0; i <= DEPTH; i++) push_vec(vec(i));
        chk("t3_full", bus.in_full, 1);
        bus.acc_ready = 1; bus.acc_valid_out = 1; y_auto = 1;
        cycles(30);
        bus.acc_ready = 0; bus.acc_valid_out = 0; y_auto = 0;
        chk("t3_in_drained", bus.in_full, 0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t3_order", bus.res_data, 8'(2 * i));
            pop_res();
        end
        chk("t3_no_extra", bus.res_empty, 1);

        // Result FIFO full: pending result waits for one pop.
        bus.acc_ready = 1; bus.acc_valid_out = 1; y_auto = 1;
        for (int i = 0; i < DEPTH; i++) push_vec(vec(i));
        cycles(20);
        push_vec(vec(4));
        cycles(6);
        chk("t4_held_off", bus.acc_ready_out, 0);
        pop_res();
        chk("t4_ready_after_pop", bus.acc_ready_out, 1);
        cyc();
        chk("t4_taken", bus.acc_ready_out, 0);
        bus.acc_ready = 0; bus.acc_valid_out = 0; y_auto = 0;
        for (int i = 1; i <= DEPTH; i++) begin
            chk("t4_order", bus.res_data, 8'(2 * i));
            pop_res();
        end
        chk("t4_empty", bus.res_empty, 1);

        // Timeout: accelerator never answers.
        d0 = m_done;
        bus.acc_ready = 1;
        push_vec(vec(7));
        cycles(3);
        bus.acc_ready = 0;
        cycles(TMO + 2);
        chk("t5_err", bus.err, 1);
        chk("t5_done_same", bus.done_cnt, d0);
        chk("t5_idle", bus.acc_valid, 0);
        push_vec(vec(8));
        wait_valid("t5_next_issue", 5);
        chk("t5_next_x1", bus.acc_x1, 8'hC8);
        bus.acc_ready = 1; cyc(); bus.acc_ready = 0;
        bus.acc_valid_out = 1; bus.acc_y = 8'h77; cyc(); bus.acc_valid_out = 0;
        chk("t5_res", bus.res_data, 8'h77);
        pop_res();

        // Random traffic, with stretches where the accelerator hangs.
        for (int c = 0; c < 3000; c++) begin
            bit hung = ((c / 150) % 4) == 3;
            bus.in_wr         = ($urandom % 3) == 0;
            bus.in_data       = $urandom;
            bus.res_rd        = ($urandom % 4) == 0;
            bus.acc_ready     = ($urandom % 2) == 0;
            bus.acc_valid_out = hung ? 1'b0 : (($urandom % 3) == 0);
            bus.acc_y         = 8'($urandom);
            cyc();
        end
        bus.in_wr = 0;

        // Reset in the middle of WAIT with data in both FIFOs.
        bus.acc_ready = 1; bus.acc_valid_out = 1; bus.res_rd = 1;
        cycles(40);
        bus.res_rd = 0;
        push_vec(vec(3));
        cycles(6);
        bus.acc_valid_out = 0;
        push_vec(vec(9));
        push_vec(vec(10));
        cycles(3);
        bus.acc_ready = 0;
        @(posedge clk);
        #3;
        arst = 1'b0;
        model_reset();
        #1;
        chk("t7_acc_valid", bus.acc_valid, 0);
        chk("t7_ready_out", bus.acc_ready_out, 0);
        chk("t7_res_empty", bus.res_empty, 1);
        chk("t7_in_full", bus.in_full, 0);
        chk("t7_res_data", bus.res_data, 8'h00);
        chk("t7_done", bus.done_cnt, 16'h0000);
        chk("t7_err", bus.err, 0);
        chk("t7_x4", bus.acc_x4, 8'h00);
        cycles(2);
        arst = 1'b1;
        cycles(4);
        chk("t7_fifo_flushed", bus.acc_valid, 0);
        push_vec(32'hAABBCCDD);
        wait_valid("t7_after_reset", 5);
        chk("t7_x1", bus.acc_x1, 8'hDD);
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
